popcount_pattern_gen: RTL

Streaming generator producing, in strictly ascending numeric order, every WIDTH-bit word whose population count equals a requested value k. It is the inverse of the pop-count datapath: the pop-count block maps a word to its count, and this block enumerates all words that map to a given count. It sits in front of the pop-count comparison harness as an exhaustive stimulus source. A ready/valid output handshake lets a downstream counter or checker apply backpressure.

---
 rtl/popcount_pattern_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/popcount_pattern_gen.sv
// Enumerates every WIDTH-bit word with exactly k ones, in ascending numeric order,
// over a valid/ready stream. Successor words come from a divider-free Gosper step.
module popcount_pattern_gen #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    k,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word,
  output logic [31:0]      index,
  output logic             last,
  output logic             err,
  output logic             state_dbg
);

  // Handshake: a word transfers on any rising edge where out_valid & out_ready;
  // word/index/last are held unchanged while out_valid is high and out_ready is low.

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam int            TW      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] WIDTH_K = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    k_q;
  logic             k_legal, accept, fire;
  logic [WIDTH-1:0] lsb, nxt, top_mask, first_word;
  logic [WIDTH:0]   sum, diff_sh;
  logic [TW-1:0]    tz;

  function automatic logic [WIDTH-1:0] low_ones(input logic [CW-1:0] n);
    logic [WIDTH:0] t;
    t = ((WIDTH+1)'(1) << n) - (WIDTH+1)'(1);
    return t[WIDTH-1:0];
  endfunction

  assign k_legal    = (k <= WIDTH_K);
  assign accept     = (state_q == IDLE) && start && k_legal;
  assign fire       = (state_q == EMIT) && out_ready;
  assign first_word = low_ones(k);
  // The final pattern has all k ones packed into the top bit positions.
  assign top_mask   = ~low_ones(WIDTH_K - k_q);

  // Gosper step: add the lowest set bit, then refill the vacated ones at the bottom.
  assign lsb     = word & (~word + WIDTH'(1));
  assign sum     = {1'b0, word} + {1'b0, lsb};
  assign diff_sh = (sum ^ {1'b0, word}) >> 2;
  assign nxt     = sum[WIDTH-1:0] | WIDTH'(diff_sh >> tz);

  always_comb begin
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (lsb[i]) tz = TW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EMIT;
      EMIT:    if (fire && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == EMIT);
  assign out_valid = (state_q == EMIT);
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      word  <= '0;
      index <= '0;
      last  <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= (state_q == IDLE) && start && !k_legal;
      if (accept) begin
        k_q   <= k;
        word  <= first_word;
        index <= '0;
        last  <= (k == '0) || (k == WIDTH_K);
      end else if (fire) begin
        if (!last) begin
          word  <= nxt;
          index <= index + 32'd1;
          last  <= (nxt == top_mask);
        end else begin
          last <= 1'b0;
        end
      end
    end
  end

  // Before the final word the increment can never carry out of WIDTH bits.
  assert property (@(posedge clk) disable iff (!rst_n) (fire && !last) |-> !sum[WIDTH]);

endmodule
